// File: rtl/cpu_pkg.sv
// Shared constants for the LEGv8 pipeline.
// Instruction width, NOP encoding and branch opcodes.
package cpu_pkg;

    localparam int INSTR_WIDTH = 32;

    // Opcode 000000 decodes to no control.
    // Rd = X31, so a NOP never triggers forwarding.
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_001F;

    localparam logic [5:0] OPC_B   = 6'b000101;
    localparam logic [5:0] OPC_BLT = 6'b010101;
    localparam logic [5:0] OPC_CBZ = 6'b101101;

endpackage

// File: rtl/fetch_decode_branch_target_gen.sv
// Branch target adder for B / B.LT / CBZ.
// Purely combinational; shared with the predictor.
module branch_target_gen
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 64
) (
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [ADDR_WIDTH-1:0]  pc,
    input  logic                   uncond_br,
    output logic [ADDR_WIDTH-1:0]  target
);

    logic [ADDR_WIDTH-1:0] imm;
    logic                  unused_opc;

    assign unused_opc = ^instr[31:26];

    // Sign-extend imm26 (B) or imm19 (CB form).
    always_comb begin
        imm = '0;
        if (uncond_br) begin
            imm = {{(ADDR_WIDTH-26){instr[25]}}, instr[25:0]};
        end else begin
            imm = {{(ADDR_WIDTH-19){instr[23]}}, instr[23:5]};
        end
    end

    // Word offset to byte offset; wraps modulo 2^ADDR_WIDTH.
    assign target = pc + {imm[ADDR_WIDTH-3:0], 2'b00};

endmodule

// File: rtl/pipe_reg.sv
// Generic pipeline register.
// Synchronous reset, write enable.
module pipe_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset wins; otherwise load when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (write_enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_decode_stage.sv
// LEGv8 front end: PC, IF/ID register, EX/MEM
// instruction history and branch redirect.
module fetch_decode_stage
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter bit                    DELAY_SLOT = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   br_taken,
    input  logic                   uncond_br,
    output logic [INSTR_WIDTH-1:0] instr_id,
    output logic [ADDR_WIDTH-1:0]  pc_id,
    output logic [INSTR_WIDTH-1:0] instr_ex,
    output logic [INSTR_WIDTH-1:0] instr_mem,
    output logic [ADDR_WIDTH-1:0]  br_target
);

    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [ADDR_WIDTH-1:0]  pc_d;
    logic [INSTR_WIDTH-1:0] instr_id_d;
    logic [ADDR_WIDTH-1:0]  pc_id_d;
    logic [INSTR_WIDTH-1:0] instr_ex_d;
    logic                   fetch_en;

    assign fetch_en  = ~stall;
    assign imem_addr = pc_q;

    branch_target_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_tgt (
        .instr    (instr_id),
        .pc       (pc_id),
        .uncond_br(uncond_br),
        .target   (br_target)
    );

    // Next PC and IF/ID contents; squash the slot when no delay slot.
    always_comb begin
        pc_d       = pc_q + ADDR_WIDTH'(4);
        instr_id_d = imem_rdata;
        pc_id_d    = pc_q;
        if (br_taken) begin
            pc_d = br_target;
            if (!DELAY_SLOT) begin
                instr_id_d = NOP_INSTR;
                pc_id_d    = '0;
            end
        end
    end

    // A stall drops a bubble into EX while ID holds.
    always_comb begin
        instr_ex_d = stall ? NOP_INSTR : instr_id;
    end

    pipe_reg #(
        .WIDTH    (ADDR_WIDTH),
        .RESET_VAL(RESET_PC)
    ) u_pc (
        .clk         (clk),
        .reset       (reset),
        .write_enable(fetch_en),
        .d           (pc_d),
        .q           (pc_q)
    );

    pipe_reg #(
        .WIDTH    (INSTR_WIDTH),
        .RESET_VAL(NOP_INSTR)
    ) u_instr_id (
        .clk         (clk),
        .reset       (reset),
        .write_enable(fetch_en),
        .d           (instr_id_d),
        .q           (instr_id)
    );

    pipe_reg #(
        .WIDTH    (ADDR_WIDTH),
        .RESET_VAL('0)
    ) u_pc_id (
        .clk         (clk),
        .reset       (reset),
        .write_enable(fetch_en),
        .d           (pc_id_d),
        .q           (pc_id)
    );

    pipe_reg #(
        .WIDTH    (INSTR_WIDTH),
        .RESET_VAL(NOP_INSTR)
    ) u_instr_ex (
        .clk         (clk),
        .reset       (reset),
        .write_enable(1'b1),
        .d           (instr_ex_d),
        .q           (instr_ex)
    );

    pipe_reg #(
        .WIDTH    (INSTR_WIDTH),
        .RESET_VAL(NOP_INSTR)
    ) u_instr_mem (
        .clk         (clk),
        .reset       (reset),
        .write_enable(1'b1),
        .d           (instr_ex),
        .q           (instr_mem)
    );

endmodule
